// File: rtl/vga_scan_timing.sv
// 640x480@60 VGA raster generator: drives coordinates into the pixel core and aligns sync/colour to the DAC.
// Optional colour-bar generator when no polygon is enabled: define VGA_TEST_PATTERN_EN.
module vga_scan_timing #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] poly_en,
    input  logic [5:0] pixel_in,
    output logic [8:0] pixel_row,
    output logic [9:0] pixel_col,
    output logic [1:0] cmp_en,
    output logic       vblank,
    output logic       frame_start,
    output logic [7:0] frame_count,
    output logic       hsync,
    output logic       vsync,
    output logic [5:0] rgb
);

    // Totals must stay <= 1024 and V_VISIBLE <= 512 so the fixed port widths hold.
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_MAX      = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX      = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic [1:0] shadow_en;
    logic       h_last;
    logic       v_last;
    logic       frame_wrap;
    logic       h_vis;
    logic       v_vis;
    logic       visible;
    logic       hs_raw;
    logic       vs_raw;

    assign h_last     = (h_cnt == H_MAX);
    assign v_last     = (v_cnt == V_MAX);
    assign frame_wrap = h_last && v_last;
    assign h_vis      = (h_cnt < H_VIS);
    assign v_vis      = (v_cnt < V_VIS);
    assign visible    = h_vis && v_vis;
    assign hs_raw     = !((h_cnt >= HS_START) && (h_cnt < HS_END));
    assign vs_raw     = !((v_cnt >= VS_START) && (v_cnt < VS_END));

    // Raster counters; enables and frame count only change on the (max,max)->(0,0) edge so no frame tears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt       <= 10'd0;
            v_cnt       <= 10'd0;
            shadow_en   <= 2'b00;
            frame_count <= 8'd0;
        end else begin
            if (h_last) begin
                h_cnt <= 10'd0;
                if (v_last) v_cnt <= 10'd0;
                else        v_cnt <= v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
            if (frame_wrap) begin
                shadow_en   <= poly_en;
                frame_count <= frame_count + 8'd1;
            end
        end
    end

    assign pixel_col   = h_vis ? h_cnt : 10'd0;
    assign pixel_row   = v_vis ? v_cnt[8:0] : 9'd0;
    assign cmp_en      = visible ? shadow_en : 2'b00;
    assign vblank      = !v_vis;
    assign frame_start = (h_cnt == 10'd0) && (v_cnt == 10'd0);

    logic hs_d1;
    logic vs_d1;
    logic de_d1;
`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar_d1;
    logic       bar_sel_d1;
`endif

    // Stage 1 lines up with the pixel core's registered colour; stage 2 drives the pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_d1 <= 1'b1;
            vs_d1 <= 1'b1;
            de_d1 <= 1'b0;
            hsync <= 1'b1;
            vsync <= 1'b1;
            rgb   <= 6'd0;
`ifdef VGA_TEST_PATTERN_EN
            bar_d1     <= 3'd0;
            bar_sel_d1 <= 1'b0;
`endif
        end else begin
            hs_d1 <= hs_raw;
            vs_d1 <= vs_raw;
            de_d1 <= visible;
            hsync <= hs_d1;
            vsync <= vs_d1;
`ifdef VGA_TEST_PATTERN_EN
            bar_d1     <= h_cnt[8:6];
            bar_sel_d1 <= (shadow_en == 2'b00);
            if (!de_d1)
                rgb <= 6'd0;
            else if (bar_sel_d1)
                rgb <= {bar_d1[2], bar_d1[2], bar_d1[1], bar_d1[1], bar_d1[0], bar_d1[0]};
            else
                rgb <= pixel_in;
`else
            rgb <= de_d1 ? pixel_in : 6'd0;
`endif
        end
    end

endmodule

// File: tb/tb_vga_scan_timing.sv
// Bench for vga_scan_timing: full-size instance for line timing/latency, shrunken instance for frame-level behaviour.
module tb_vga_scan_timing;

    localparam int A_HV = 640, A_HF = 16, A_HS = 96, A_HB = 48;
    localparam int A_VV = 480, A_VF = 10, A_VS = 2,  A_VB = 33;
    localparam int A_FT = (A_HV + A_HF + A_HS + A_HB) * (A_VV + A_VF + A_VS + A_VB);
    localparam int B_HV = 4, B_HF = 1, B_HS = 2, B_HB = 1;
    localparam int B_VV = 4, B_VF = 1, B_VS = 2, B_VB = 1;
    localparam int B_FT = (B_HV + B_HF + B_HS + B_HB) * (B_VV + B_VF + B_VS + B_VB);

    typedef struct packed {
        logic [9:0] col;
        logic [8:0] row;
        logic [1:0] cmp;
        logic       vb;
        logic       fs;
        logic       hs;
        logic       vs;
        logic [5:0] rgb;
        logic [7:0] fc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] poly_en = 2'b00;
    logic [5:0] pix_a = 6'd0, pix_b = 6'd0;
    logic [8:0] pixel_row_a, pixel_row_b;
    logic [9:0] pixel_col_a, pixel_col_b;
    logic [1:0] cmp_en_a, cmp_en_b;
    logic       vblank_a, vblank_b, frame_start_a, frame_start_b;
    logic [7:0] frame_count_a, frame_count_b;
    logic       hsync_a, hsync_b, vsync_a, vsync_b;
    logic [5:0] rgb_a, rgb_b;
    exp_t       act_a, act_b;

    int tests_run = 0;
    int tests_failed = 0;
    int k = 0;
    int pk_c = 1, pk_r = 0, pk_s = 0;
    logic [1:0] en_a [0:511];
    logic [1:0] en_b [0:511];

    always #5 clk = ~clk;

    vga_scan_timing dut_a (
        .clk(clk), .rst_n(rst_n), .poly_en(poly_en), .pixel_in(pix_a),
        .pixel_row(pixel_row_a), .pixel_col(pixel_col_a), .cmp_en(cmp_en_a),
        .vblank(vblank_a), .frame_start(frame_start_a), .frame_count(frame_count_a),
        .hsync(hsync_a), .vsync(vsync_a), .rgb(rgb_a)
    );

    vga_scan_timing #(
        .H_VISIBLE(B_HV), .H_FRONT(B_HF), .H_SYNC(B_HS), .H_BACK(B_HB),
        .V_VISIBLE(B_VV), .V_FRONT(B_VF), .V_SYNC(B_VS), .V_BACK(B_VB)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .poly_en(poly_en), .pixel_in(pix_b),
        .pixel_row(pixel_row_b), .pixel_col(pixel_col_b), .cmp_en(cmp_en_b),
        .vblank(vblank_b), .frame_start(frame_start_b), .frame_count(frame_count_b),
        .hsync(hsync_b), .vsync(vsync_b), .rgb(rgb_b)
    );

    assign act_a = {pixel_col_a, pixel_row_a, cmp_en_a, vblank_a, frame_start_a,
                    hsync_a, vsync_a, rgb_a, frame_count_a};
    assign act_b = {pixel_col_b, pixel_row_b, cmp_en_b, vblank_b, frame_start_b,
                    hsync_b, vsync_b, rgb_b, frame_count_b};

    // Stand-in for the pixel core: a registered colour computed from the coordinates it is given.
    always @(posedge clk) begin
        pix_a <= 6'(int'(pixel_col_a) * pk_c + int'(pixel_row_a) * pk_r + pk_s);
        pix_b <= 6'(int'(pixel_col_b) * pk_c + int'(pixel_row_b) * pk_r + pk_s);
    end

    // Reference: position from elapsed cycles k; pins show the coordinate from two cycles earlier.
    function automatic exp_t model(input int kk, input int hv, input int hf, input int hs,
                                   input int hb, input int vv, input int vf, input int vs,
                                   input int vb, input logic [1:0] en_cur, input logic [1:0] en_k2);
        int ht, vt, h, v, h2, v2;
        logic [9:0] c2;
        exp_t e;
        ht = hv + hf + hs + hb;
        vt = vv + vf + vs + vb;
        h = kk % ht;
        v = (kk / ht) % vt;
        e.col = (h < hv) ? 10'(h) : 10'd0;
        e.row = (v < vv) ? 9'(v) : 9'd0;
        e.cmp = (h < hv && v < vv) ? en_cur : 2'b00;
        e.vb  = (v >= vv);
        e.fs  = (h == 0 && v == 0);
        e.fc  = 8'((kk / (ht * vt)) % 256);
        e.hs  = 1'b1;
        e.vs  = 1'b1;
        e.rgb = 6'd0;
        if (kk >= 2) begin
            h2 = (kk - 2) % ht;
            v2 = ((kk - 2) / ht) % vt;
            e.hs = !(h2 >= hv + hf && h2 < hv + hf + hs);
            e.vs = !(v2 >= vv + vf && v2 < vv + vf + vs);
            if (h2 < hv && v2 < vv) begin
                e.rgb = 6'(h2 * pk_c + v2 * pk_r + pk_s);
`ifdef VGA_TEST_PATTERN_EN
                if (en_k2 == 2'b00) begin
                    c2 = 10'(h2);
                    e.rgb = {c2[8], c2[8], c2[7], c2[7], c2[6], c2[6]};
                end
`endif
            end
        end
        return e;
    endfunction

    function automatic exp_t exp_a(input int kk);
        return model(kk, A_HV, A_HF, A_HS, A_HB, A_VV, A_VF, A_VS, A_VB,
                     en_a[(kk / A_FT) % 512], (kk >= 2) ? en_a[((kk - 2) / A_FT) % 512] : 2'b00);
    endfunction

    function automatic exp_t exp_b(input int kk);
        return model(kk, B_HV, B_HF, B_HS, B_HB, B_VV, B_VF, B_VS, B_VB,
                     en_b[(kk / B_FT) % 512], (kk >= 2) ? en_b[((kk - 2) / B_FT) % 512] : 2'b00);
    endfunction

    task automatic clear_model();
        k = 0;
        for (int i = 0; i < 512; i++) begin
            en_a[i] = 2'b00;
            en_b[i] = 2'b00;
        end
    endtask

    // Advance one clock; the enable present at a frame-wrap edge becomes the next frame's enable.
    task automatic tick();
        if ((k + 1) % A_FT == 0) en_a[((k + 1) / A_FT) % 512] = poly_en;
        if ((k + 1) % B_FT == 0) en_b[((k + 1) / B_FT) % 512] = poly_en;
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_model();
    endtask

    task automatic test_reset();
        exp_t e;
        poly_en = 2'b11;
        pk_c = int'($urandom_range(1, 63));
        pk_r = int'($urandom_range(0, 63));
        pk_s = int'($urandom_range(0, 63));
        do_reset();
        for (int i = 0; i < 300; i++) begin
            e = exp_a(k);
            tests_run++;
            if (act_a !== e) begin
                tests_failed++;
                $display("FAIL reset_preroll k=%0d got=%h exp=%h", k, act_a, e);
            end
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({hsync_a, vsync_a, rgb_a, cmp_en_a, pixel_col_a} !== {1'b1, 1'b1, 6'd0, 2'b00, 10'd0}) begin
            tests_failed++;
            $display("FAIL reset_async hs=%b vs=%b rgb=%h cmp=%b col=%0d exp hs=1 vs=1 rgb=0 cmp=0 col=0",
                     hsync_a, vsync_a, rgb_a, cmp_en_a, pixel_col_a);
        end
        tests_run++;
        if ({frame_start_a, vblank_a, pixel_row_a, frame_count_a} !== {1'b1, 1'b0, 9'd0, 8'd0}) begin
            tests_failed++;
            $display("FAIL reset_state fs=%b vb=%b row=%0d fc=%0d exp fs=1 vb=0 row=0 fc=0",
                     frame_start_a, vblank_a, pixel_row_a, frame_count_a);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_model();
        for (int i = 0; i < 40; i++) begin
            tests_run++;
            if (pixel_col_a !== 10'(k)) begin
                tests_failed++;
                $display("FAIL reset_release_col k=%0d got=%0d exp=%0d", k, pixel_col_a, k);
            end
            e = exp_a(k);
            tests_run++;
            if (act_a !== e) begin
                tests_failed++;
                $display("FAIL reset_release k=%0d got=%h exp=%h", k, act_a, e);
            end
            tick();
        end
    endtask

    task automatic test_horizontal();
        exp_t e;
        int falls [0:3];
        int n_fall, n_low;
        logic prev_hs;
        pk_c = int'($urandom_range(1, 63));
        pk_r = int'($urandom_range(0, 63));
        pk_s = int'($urandom_range(0, 63));
        do_reset();
        n_fall = 0;
        n_low = 0;
        prev_hs = 1'b1;
        for (int i = 0; i < 1604; i++) begin
            if ($urandom_range(0, 99) == 0) poly_en = 2'($urandom);
            e = exp_a(k);
            tests_run++;
            if (act_a !== e) begin
                tests_failed++;
                $display("FAIL horiz k=%0d got=%h exp=%h", k, act_a, e);
            end
            if (prev_hs && !hsync_a && n_fall < 4) begin
                falls[n_fall] = k;
                n_fall++;
            end
            if (!hsync_a) n_low++;
            prev_hs = hsync_a;
            tick();
        end
        tests_run++;
        if (n_fall !== 2 || falls[0] !== 658 || falls[1] !== 1458) begin
            tests_failed++;
            $display("FAIL hsync_edges falls=%0d first=%0d second=%0d exp 2 658 1458",
                     n_fall, falls[0], falls[1]);
        end
        tests_run++;
        if (n_low !== 192) begin
            tests_failed++;
            $display("FAIL hsync_width low_cycles=%0d exp=192", n_low);
        end
    endtask

    task automatic test_latency();
        logic [5:0] exp5, exp639;
        pk_c = 1;
        pk_r = 0;
        pk_s = 0;
        poly_en = 2'b00;
`ifdef VGA_TEST_PATTERN_EN
        exp5 = 6'b000000;
        exp639 = 6'b000011;
`else
        exp5 = 6'd5;
        exp639 = 6'd63;
`endif
        do_reset();
        while (k < 7) tick();
        tests_run++;
        if (rgb_a !== exp5 || hsync_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL latency_col5 rgb=%0d hs=%b exp rgb=%0d hs=1", rgb_a, hsync_a, exp5);
        end
`ifdef VGA_TEST_PATTERN_EN
        while (k < 66) tick();
        tests_run++;
        if (rgb_a !== 6'b000011) begin
            tests_failed++;
            $display("FAIL bars_col64 rgb=%b exp=000011", rgb_a);
        end
        while (k < 450) tick();
        tests_run++;
        if (rgb_a !== 6'b111111) begin
            tests_failed++;
            $display("FAIL bars_col448 rgb=%b exp=111111", rgb_a);
        end
`endif
        while (k < 641) tick();
        tests_run++;
        if (rgb_a !== exp639) begin
            tests_failed++;
            $display("FAIL latency_col639 rgb=%0d exp=%0d", rgb_a, exp639);
        end
        tick();
        tests_run++;
        if (rgb_a !== 6'd0) begin
            tests_failed++;
            $display("FAIL latency_col640 rgb=%0d exp=0", rgb_a);
        end
    endtask

    task automatic test_vertical();
        exp_t e;
        int n_fs, n_vs_low, n_vb, first_vs_fall;
        logic prev_vs;
        pk_c = int'($urandom_range(1, 63));
        pk_r = int'($urandom_range(1, 63));
        pk_s = int'($urandom_range(0, 63));
        poly_en = 2'($urandom);
        do_reset();
        n_fs = 0;
        n_vs_low = 0;
        n_vb = 0;
        first_vs_fall = -1;
        prev_vs = 1'b1;
        for (int i = 0; i < 132; i++) begin
            e = exp_b(k);
            tests_run++;
            if (act_b !== e) begin
                tests_failed++;
                $display("FAIL vert k=%0d got=%h exp=%h", k, act_b, e);
            end
            if (frame_start_b) n_fs++;
            if (!vsync_b) n_vs_low++;
            if (vblank_b) n_vb++;
            if (prev_vs && !vsync_b && first_vs_fall < 0) first_vs_fall = k;
            prev_vs = vsync_b;
            tick();
        end
        tests_run++;
        if (n_fs !== 3 || n_vb !== 64) begin
            tests_failed++;
            $display("FAIL vert_counts frame_start=%0d vblank=%0d exp 3 64", n_fs, n_vb);
        end
        tests_run++;
        if (n_vs_low !== 32 || first_vs_fall !== 42) begin
            tests_failed++;
            $display("FAIL vsync_timing low=%0d first_fall=%0d exp 32 42", n_vs_low, first_vs_fall);
        end
    endtask

    task automatic test_shadow();
        exp_t e;
        int chg_k [0:4];
        logic [1:0] chg_v [0:4];
        for (int f = 0; f < 5; f++) begin
            chg_k[f] = f * B_FT + int'($urandom_range(0, 3)) * 8 + int'($urandom_range(0, 3));
            chg_v[f] = 2'($urandom_range(1, 3));
        end
        poly_en = 2'b00;
        do_reset();
        for (int i = 0; i < 5 * B_FT + 3; i++) begin
            for (int f = 0; f < 5; f++)
                if (k == chg_k[f]) poly_en = chg_v[f];
            if (k == B_FT) begin
                tests_run++;
                if (cmp_en_b !== chg_v[0]) begin
                    tests_failed++;
                    $display("FAIL shadow_frame1 cmp=%b exp=%b", cmp_en_b, chg_v[0]);
                end
            end
            e = exp_b(k);
            tests_run++;
            if (act_b !== e) begin
                tests_failed++;
                $display("FAIL shadow k=%0d got=%h exp=%h", k, act_b, e);
            end
            tick();
        end
    endtask

    task automatic test_frame_wrap();
        exp_t e;
        pk_c = int'($urandom_range(1, 63));
        pk_r = int'($urandom_range(1, 63));
        pk_s = int'($urandom_range(0, 63));
        do_reset();
        for (int i = 0; i < 256 * B_FT + 3; i++) begin
            if (k % B_FT == 10) poly_en = 2'($urandom);
            if (k == 255 * B_FT) begin
                tests_run++;
                if (frame_count_b !== 8'd255) begin
                    tests_failed++;
                    $display("FAIL wrap_255 fc=%0d exp=255", frame_count_b);
                end
            end
            if (k == 256 * B_FT) begin
                tests_run++;
                if (frame_count_b !== 8'd0) begin
                    tests_failed++;
                    $display("FAIL wrap_0 fc=%0d exp=0", frame_count_b);
                end
            end
            e = exp_b(k);
            tests_run++;
            if (act_b !== e) begin
                tests_failed++;
                $display("FAIL wrap k=%0d got=%h exp=%h", k, act_b, e);
            end
            tick();
        end
    endtask

    initial begin
        clear_model();
        test_reset();
        test_horizontal();
        test_latency();
        test_vertical();
        test_shadow();
        test_frame_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
